uart_rx_baudsel: RTL and testbench

//   8N1 UART receiver; the RX counterpart of the board's TX path. Deserialises DataIn into
//   a byte using a baud rate chosen by the 2-bit mode-switch selector (SW[2:1] via the mode mux).

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx_baudsel.sv | 151 +++++++++++++++
 tb/tb_uart_rx_baudsel.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial RX bundle: line input and rate select in, received byte and status out.
// The bench drives through master; the receiver consumes through slave.
interface uart_rx_if;
    logic [1:0] baud_sel;
    logic       DataIn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output baud_sel,
        output DataIn,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  baud_sel,
        input  DataIn,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_baudsel.sv
// 8N1 UART receiver with selectable baud rate, mid-bit sampling,
// start-glitch rejection and framing-error detection.
module uart_rx_baudsel #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 13
) (
    input  logic      src_clk,
    input  logic      rst_n,
    uart_rx_if.slave  rx
);

    localparam logic [CNT_W-1:0] DIV0 = CNT_W'(CLK_HZ / 115200);
    localparam logic [CNT_W-1:0] DIV1 = CNT_W'(CLK_HZ / 57600);
    localparam logic [CNT_W-1:0] DIV2 = CNT_W'(CLK_HZ / 19200);
    localparam logic [CNT_W-1:0] DIV3 = CNT_W'(CLK_HZ / 9600);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    state_t           state, stateN;
    logic             sync1, rxs;
    logic [CNT_W-1:0] cnt, cntN;
    logic [CNT_W-1:0] divQ, divQN, divSel;
    logic [2:0]       idx, idxN;
    logic [7:0]       shreg, shregN;
    logic [7:0]       dataQ, dataN;
    logic             validQ, validN;
    logic             ferrQ, ferrN;
    logic             busyQ, busyN;

    always_comb begin
        divSel = DIV0;
        unique case (rx.baud_sel)
            2'b00: divSel = DIV0;
            2'b01: divSel = DIV1;
            2'b10: divSel = DIV2;
            2'b11: divSel = DIV3;
        endcase
    end

    always_comb begin
        stateN = state;
        cntN   = cnt;
        divQN  = divQ;
        idxN   = idx;
        shregN = shreg;
        dataN  = dataQ;
        validN = 1'b0;
        ferrN  = 1'b0;
        busyN  = busyQ;
        unique case (state)
            IDLE: begin
                cntN = '0;
                if (!rxs) begin
                    divQN  = divSel;
                    cntN   = (divSel >> 1) - ONE;
                    busyN  = 1'b1;
                    stateN = START;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cntN = cnt - ONE;
                end else if (!rxs) begin
                    cntN   = divQ - ONE;
                    idxN   = '0;
                    stateN = DATA;
                end else begin
                    // line went back high before mid-start: treat as noise
                    busyN  = 1'b0;
                    stateN = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cntN = cnt - ONE;
                end else begin
                    shregN[idx] = rxs;
                    cntN        = divQ - ONE;
                    if (idx == 3'd7) stateN = STOP;
                    else idxN = idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cntN = cnt - ONE;
                end else begin
                    cntN = '0;
                    if (rxs) begin
                        dataN  = shreg;
                        validN = 1'b1;
                        busyN  = 1'b0;
                        stateN = IDLE;
                    end else begin
                        ferrN  = 1'b1;
                        stateN = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                // a break must end before a new start edge can count
                cntN = '0;
                if (rxs) begin
                    busyN  = 1'b0;
                    stateN = IDLE;
                end
            end
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            rxs    <= 1'b1;
            state  <= IDLE;
            cnt    <= '0;
            divQ   <= '0;
            idx    <= '0;
            shreg  <= '0;
            dataQ  <= 8'h00;
            validQ <= 1'b0;
            ferrQ  <= 1'b0;
            busyQ  <= 1'b0;
        end else begin
            sync1  <= rx.DataIn;
            rxs    <= sync1;
            state  <= stateN;
            cnt    <= cntN;
            divQ   <= divQN;
            idx    <= idxN;
            shreg  <= shregN;
            dataQ  <= dataN;
            validQ <= validN;
            ferrQ  <= ferrN;
            busyQ  <= busyN;
        end
    end

    assign rx.rx_data   = dataQ;
    assign rx.rx_valid  = validQ;
    assign rx.frame_err = ferrQ;
    assign rx.rx_busy   = busyQ;

endmodule

// File: tb/tb_uart_rx_baudsel.sv
// Randomised and directed 8N1 frames checked against a queue-based
// frame model: expected pulse kind, byte and arrival cycle per frame.
`timescale 1ns/1ps
module tb_uart_rx_baudsel;

    localparam int CLK_HZ = 5_000_000;
    localparam int T      = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #(T/2) clk = ~clk;

    uart_rx_if rxIf();

    uart_rx_baudsel #(
        .CLK_HZ(CLK_HZ),
        .CNT_W (13)
    ) dut (
        .src_clk(clk),
        .rst_n  (rst_n),
        .rx     (rxIf)
    );

    typedef struct {
        bit         isValid;
        logic [7:0] data;
        int         st;
        int         pred;
    } exp_t;

    exp_t       expQ[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         ferrCount = 0;
    int         lastValidCyc = -1;
    logic [7:0] lastGood = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int divOf(input logic [1:0] s);
        case (s)
            2'b00:   return CLK_HZ / 115200;
            2'b01:   return CLK_HZ / 57600;
            2'b10:   return CLK_HZ / 19200;
            default: return CLK_HZ / 9600;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h need %0h (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic chkRange(input string name, input int act,
                            input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d need %0d..%0d",
                     name, act, lo, hi);
        end
    endtask

    // Per-cycle comparison against the frame model
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rxIf.rx_valid || rxIf.frame_err) begin
                chk("pulse_exclusive",
                    int'(rxIf.rx_valid & rxIf.frame_err), 0);
                if (rxIf.frame_err) ferrCount++;
                if (expQ.size() == 0) begin
                    chk("unexpected_pulse",
                        int'({rxIf.rx_valid, rxIf.frame_err}), 0);
                end else begin
                    e = expQ.pop_front();
                    chk("pulse_kind", int'(rxIf.rx_valid),
                        int'(e.isValid));
                    chkRange("pulse_cycle", cyc,
                             e.pred - 1, e.pred + 1);
                    if (e.isValid) begin
                        lastGood     = e.data;
                        lastValidCyc = cyc;
                    end
                end
                if (rxIf.rx_valid)
                    chk("busy_at_valid", int'(rxIf.rx_busy), 0);
            end else if (expQ.size() > 0 &&
                         cyc > expQ[0].pred + 1) begin
                e = expQ.pop_front();
                chk("missing_pulse", 0, 1);
            end
            if (expQ.size() > 0 &&
                cyc >= expQ[0].st + 4 &&
                cyc <= expQ[0].pred - 2)
                chk("busy_mid_frame", int'(rxIf.rx_busy), 1);
            chk("rx_data_hold", int'(rxIf.rx_data), int'(lastGood));
        end
    end

    task automatic sendFrame(input logic [7:0] b,
                             input logic [1:0] sel,
                             input bit stopHigh,
                             input int flipAfter,
                             input logic [1:0] flipSel,
                             output int st);
        int   d;
        exp_t e;
        d = divOf(sel);
        @(negedge clk);
        rxIf.baud_sel = sel;
        rxIf.DataIn   = 1'b0;
        st            = cyc;
        e.isValid     = stopHigh;
        e.data        = b;
        e.st          = st;
        e.pred        = st + 2 + d / 2 + 9 * d;
        expQ.push_back(e);
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxIf.DataIn = b[i];
            repeat (d) @(negedge clk);
            if (i == flipAfter) rxIf.baud_sel = flipSel;
        end
        rxIf.DataIn = stopHigh;
        repeat (d) @(negedge clk);
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_data"},  int'(rxIf.rx_data), 0);
        chk({tag, "_valid"}, int'(rxIf.rx_valid), 0);
        chk({tag, "_ferr"},  int'(rxIf.frame_err), 0);
        chk({tag, "_busy"},  int'(rxIf.rx_busy), 0);
    endtask

    initial begin
        #(T * 90000);
        $display("FAIL watchdog: timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int   st, d, f0, lat;
        int   latTab[4];
        logic [7:0] b;
        logic [1:0] s;
        bit   stp;
        latTab = '{410, 819, 2472, 4942};

        rxIf.DataIn   = 1'b1;
        rxIf.baud_sel = 2'b01;
        repeat (3) @(negedge clk);
        chkReset("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5 at 57600
        sendFrame(8'hA5, 2'b01, 1'b1, -1, 2'b00, st);
        chk("t1_data", int'(rxIf.rx_data), 8'hA5);
        chkRange("t1_latency", lastValidCyc - st, 818, 820);
        chk("t1_no_ferr", ferrCount, 0);

        // every rate
        for (int i = 0; i < 4; i++) begin
            sendFrame(8'h3C, 2'(i), 1'b1, -1, 2'b00, st);
            chk("t2_data", int'(rxIf.rx_data), 8'h3C);
            chkRange("t2_latency", lastValidCyc - st,
                     latTab[i] - 1, latTab[i] + 1);
        end

        // short low glitch at 9600
        d = divOf(2'b11);
        @(negedge clk);
        rxIf.baud_sel = 2'b11;
        repeat (2) @(negedge clk);
        #10 rxIf.DataIn = 1'b0;
        #500 rxIf.DataIn = 1'b1;
        repeat (5) @(negedge clk);
        chk("t3_busy_start", int'(rxIf.rx_busy), 1);
        repeat (d / 2 + 5) @(negedge clk);
        chk("t3_busy_drop", int'(rxIf.rx_busy), 0);
        chk("t3_no_ferr", ferrCount, 0);

        // stop bit low then held break
        d  = divOf(2'b10);
        f0 = ferrCount;
        sendFrame(8'h55, 2'b10, 1'b0, -1, 2'b00, st);
        chk("t4_ferr_pulse", ferrCount - f0, 1);
        chk("t4_data_kept", int'(rxIf.rx_data), 8'h3C);
        repeat (20 * d) @(negedge clk);
        chk("t4_busy_hold", int'(rxIf.rx_busy), 1);
        chk("t4_no_retrig", ferrCount - f0, 1);
        rxIf.DataIn = 1'b1;
        repeat (8) @(negedge clk);
        chk("t4_busy_release", int'(rxIf.rx_busy), 0);
        sendFrame(8'h81, 2'b10, 1'b1, -1, 2'b00, st);
        chk("t4_data", int'(rxIf.rx_data), 8'h81);

        // baud_sel flips mid-frame
        sendFrame(8'hF0, 2'b01, 1'b1, 3, 2'b11, st);
        chk("t5_data", int'(rxIf.rx_data), 8'hF0);
        chkRange("t5_latency", lastValidCyc - st, 818, 820);
        sendFrame(8'hC3, 2'b11, 1'b1, -1, 2'b00, st);
        chk("t5_next_data", int'(rxIf.rx_data), 8'hC3);
        chkRange("t5_next_latency", lastValidCyc - st, 4941, 4943);

        // reset during data bit 5
        d = divOf(2'b01);
        b = 8'h6A;
        @(negedge clk);
        rxIf.baud_sel = 2'b01;
        rxIf.DataIn   = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rxIf.DataIn = b[i];
            repeat (d) @(negedge clk);
        end
        rxIf.DataIn = b[5];
        repeat (d / 2) @(negedge clk);
        chk("t6_busy_before", int'(rxIf.rx_busy), 1);
        #(T/4);
        rst_n = 1'b0;
        expQ.delete();
        lastGood = 8'h00;
        #1;
        chkReset("t6_reset");
        @(negedge clk);
        rxIf.DataIn = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * d) @(negedge clk);
        sendFrame(8'h0F, 2'b01, 1'b1, -1, 2'b00, st);
        chk("t6_data", int'(rxIf.rx_data), 8'h0F);

        // random frames, rates, gaps and framing errors
        for (int n = 0; n < 6; n++) begin
            b   = 8'($urandom);
            s   = 2'($urandom_range(0, 3));
            stp = ($urandom_range(0, 3) != 0);
            sendFrame(b, s, stp, -1, 2'b00, st);
            if (!stp) begin
                rxIf.DataIn = 1'b1;
                repeat (divOf(s)) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
